// File: rtl/tlp_rx_checker_if.sv
// Bundles the TLP receive stream, the ack/nack return path and the committed payload stream.
// The checker connects through the slave modport; the transmitter/consumer side uses master.
interface tlp_rx_checker_if;
  logic [31:0] rx_tlp_data;
  logic        rx_tlp_valid;
  logic        rx_tlp_ready;
  logic        ack;
  logic        nack;
  logic [11:0] ack_seq;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output rx_tlp_data, rx_tlp_valid, out_ready,
    input  rx_tlp_ready, ack, nack, ack_seq, out_data, out_last, out_valid
  );

  modport slave (
    input  rx_tlp_data, rx_tlp_valid, out_ready,
    output rx_tlp_ready, ack, nack, ack_seq, out_data, out_last, out_valid
  );
endinterface

// File: rtl/tlp_rx_checker.sv
// DLL receive checker: seq/XOR check, ack/nack pulses, speculative payload buffer with commit.
// Optional mid-frame idle timeout is enabled by defining TLP_RX_TIMEOUT_EN.
module tlp_rx_checker #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  tlp_rx_checker_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (MAX_LEN > DEPTH || MAX_LEN == 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("tlp_rx_checker: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StPayload, StCheck} state_e;

  state_e        state_q, state_d;
  logic [32:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, cmt_ptr_q, rd_ptr_q;
  logic [11:0]   seq_q, exp_q, ack_seq_q, ack_seq_d;
  logic [8:0]    cnt_q;
  logic [31:0]   xor_q;
  logic          ack_q, nack_q, ack_d, nack_d;

  logic          ready, hs, full, pop, wr_en, commit, rollback, xor_ok, out_valid, tmo_abort;
  logic [PW-1:0] used;
  logic [11:0]   hdr_seq;
  logic [8:0]    hdr_len;

  assign hdr_seq   = bus.rx_tlp_data[11:0];
  assign hdr_len   = bus.rx_tlp_data[20:12];
  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == PW'(DEPTH));
  assign hs        = bus.rx_tlp_valid && ready;
  assign xor_ok    = (xor_q == bus.rx_tlp_data);
  assign out_valid = (rd_ptr_q != cmt_ptr_q);
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StPayload: ready = !full;
        default:   ready = 1'b1;
      endcase
    end
  end

`ifdef TLP_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  // tmo_q counts earlier idle cycles, so this fires on the TIMEOUT-th idle cycle.
  assign tmo_abort = (state_q != StIdle) && !hs && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || hs || tmo_abort || state_q == StIdle) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    ack_seq_d = seq_q;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          if (hdr_len == 9'd0 || hdr_len > 9'(MAX_LEN)) begin
            nack_d    = 1'b1;
            ack_seq_d = hdr_seq;
          end else begin
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (hs) begin
          wr_en = 1'b1;
          if (cnt_q == 9'd1) state_d = StCheck;
        end
      end
      StCheck: begin
        if (hs) begin
          state_d = StIdle;
          if (xor_ok && seq_q == exp_q) begin
            ack_d  = 1'b1;
            commit = 1'b1;
          end else if (xor_ok && seq_q == exp_q - 12'd1) begin
            ack_d    = 1'b1;
            rollback = 1'b1;
          end else begin
            nack_d   = 1'b1;
            rollback = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (tmo_abort) begin
      state_d  = StIdle;
      nack_d   = 1'b1;
      rollback = 1'b1;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      seq_q     <= '0;
      exp_q     <= '0;
      ack_seq_q <= '0;
      cnt_q     <= '0;
      xor_q     <= '0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      if (ack_d || nack_d) ack_seq_q <= ack_seq_d;
      if (state_q == StIdle && hs) begin
        seq_q <= hdr_seq;
        cnt_q <= hdr_len;
        xor_q <= bus.rx_tlp_data;
      end
      if (wr_en) begin
        xor_q    <= xor_q ^ bus.rx_tlp_data;
        cnt_q    <= cnt_q - 9'd1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (commit) begin
        cmt_ptr_q <= wr_ptr_q;
        exp_q     <= exp_q + 12'd1;
      end
      if (rollback) wr_ptr_q <= cmt_ptr_q;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload storage has no reset; only entries below the commit pointer are ever exposed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {cnt_q == 9'd1, bus.rx_tlp_data};
  end

  assign bus.rx_tlp_ready = ready;
  assign bus.ack          = ack_q;
  assign bus.nack         = nack_q;
  assign bus.ack_seq      = ack_seq_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_valid ? mem_q[rd_ptr_q[AW-1:0]][31:0] : 32'h0;
  assign bus.out_last     = out_valid ? mem_q[rd_ptr_q[AW-1:0]][32] : 1'b0;
endmodule

// File: tb/tb_tlp_rx_checker.sv
// Self-checking bench for tlp_rx_checker: frame-level reference model plus directed/random frames.
// Define TLP_RX_TIMEOUT_EN to build and exercise the idle-timeout abort.
module tb_tlp_rx_checker;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlp_rx_checker_if ifc ();

  tlp_rx_checker #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;
  bit rand_rdy = 1'b0;

  // Reference model state: words of the frame in flight and committed-but-unread payload.
  logic [31:0] fw[$];
  logic [32:0] mq[$];
  int unsigned exp_seq = 0;
  bit          exp_ack = 1'b0, exp_nack = 1'b0;
  logic [11:0] exp_aseq = '0;
  int unsigned stall = 0;

  // Observations of the DUT, used by the directed literal checks.
  int          n_ack = 0, n_nack = 0;
  logic [11:0] last_aseq = '0;
  logic [32:0] out_log[$];
  logic [31:0] txq[$];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mdl_ready();
    int unsigned len;
    if (rst) return 1'b0;
    if (fw.size() == 0) return 1'b1;
    len = int'(fw[0][20:12]);
    if (fw.size() <= len) return (mq.size() + fw.size() - 1) < DEPTH;
    return 1'b1;
  endfunction

  task automatic decide();
    int unsigned len;
    logic [31:0] x;
    int unsigned seq;
    len = int'(fw[0][20:12]);
    if (fw.size() == 1) begin
      if (len == 0 || len > MAX_LEN) begin
        exp_nack = 1'b1;
        exp_aseq = fw[0][11:0];
        fw.delete();
      end
    end else if (fw.size() == len + 2) begin
      x = 32'h0;
      for (int i = 0; i <= int'(len); i++) x ^= fw[i];
      seq = int'(fw[0][11:0]);
      exp_aseq = fw[0][11:0];
      if (x == fw[len+1] && seq == exp_seq) begin
        exp_ack = 1'b1;
        for (int i = 1; i <= int'(len); i++) mq.push_back({i == int'(len), fw[i]});
        exp_seq = (exp_seq + 1) % 4096;
      end else if (x == fw[len+1] && seq == (exp_seq + 4095) % 4096) begin
        exp_ack = 1'b1;
      end else begin
        exp_nack = 1'b1;
      end
      fw.delete();
    end
  endtask

  always @(posedge clk) begin
    bit hs;
    hs = mdl_ready() && ifc.rx_tlp_valid;
    if (rst) begin
      fw.delete();
      mq.delete();
      exp_seq  = 0;
      exp_ack  = 1'b0;
      exp_nack = 1'b0;
      stall    = 0;
    end else begin
      exp_ack  = 1'b0;
      exp_nack = 1'b0;
      if (mq.size() != 0 && ifc.out_ready) void'(mq.pop_front());
      if (hs) begin
        stall = 0;
        fw.push_back(ifc.rx_tlp_data);
        decide();
      end else if (fw.size() != 0) begin
`ifdef TLP_RX_TIMEOUT_EN
        stall++;
        if (stall == TIMEOUT) begin
          exp_nack = 1'b1;
          exp_aseq = fw[0][11:0];
          fw.delete();
          stall = 0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("rx_tlp_ready", ifc.rx_tlp_ready, mdl_ready());
      chk("ack", ifc.ack, exp_ack);
      chk("nack", ifc.nack, exp_nack);
      if (exp_ack || exp_nack) chk("ack_seq", ifc.ack_seq, exp_aseq);
      chk("out_valid", ifc.out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("out_word", {ifc.out_last, ifc.out_data}, mq[0]);
      if (!rst) begin
        if (ifc.ack) n_ack++;
        if (ifc.nack) n_nack++;
        if (ifc.ack || ifc.nack) last_aseq = ifc.ack_seq;
        if (ifc.out_valid && ifc.out_ready) out_log.push_back({ifc.out_last, ifc.out_data});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int n;
    bit r;
    n = 0;
    ifc.rx_tlp_valid = 1'b1;
    ifc.rx_tlp_data  = w;
    do begin
      @(negedge clk);
      r = ifc.rx_tlp_ready;
      idle(1);
      n++;
    end while (!r && n < 3000);
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL handshake_wait: ready stayed 0 for %0d cycles, required 1", n);
    end
    ifc.rx_tlp_valid = 1'b0;
    if (gaps) idle($urandom_range(0, 2));
  endtask

  task automatic build_frame(input logic [11:0] seq, input int unsigned len, input bit bad,
                             input bit rnd);
    logic [31:0] x;
    logic [31:0] d;
    txq.delete();
    txq.push_back({rnd ? 11'($urandom) : 11'h0, 9'(len), seq});
    if (len == 0 || len > MAX_LEN) return;
    x = txq[0];
    for (int i = 1; i <= int'(len); i++) begin
      d = rnd ? $urandom : 32'h11 * i;
      txq.push_back(d);
      x ^= d;
    end
    txq.push_back(x ^ {31'h0, bad});
  endtask

  task automatic send_frame(input logic [11:0] seq, input int unsigned len, input bit bad,
                            input bit rnd);
    build_frame(seq, len, bad, rnd);
    foreach (txq[i]) send_word(txq[i], rnd);
  endtask

  initial begin
    int base_ack, base_nack;
    rst = 1'b1;
    ifc.rx_tlp_valid = 1'b0;
    ifc.rx_tlp_data  = '0;
    ifc.out_ready    = 1'b1;
    @(posedge clk);
    #1;
    run_chk = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Bad check word (bit0 flipped): nack, nothing released.
    send_frame(12'd0, 3, 1'b1, 1'b0);
    idle(4);
    chk("bad_xor_nack", n_nack, 1);
    chk("bad_xor_seq", last_aseq, 0);
    chk("bad_xor_no_out", out_log.size(), 0);
    chk("bad_xor_exp", exp_seq, 0);

    // Good frame seq0 len3: ack, payload 0x11/0x22/0x33 with last on the final word.
    send_frame(12'd0, 3, 1'b0, 1'b0);
    idle(6);
    chk("good_ack", n_ack, 1);
    chk("good_seq", last_aseq, 0);
    chk("good_cnt", out_log.size(), 3);
    chk("good_w0", out_log[0], 33'h0_0000_0011);
    chk("good_w1", out_log[1], 33'h0_0000_0022);
    chk("good_w2", out_log[2], 33'h1_0000_0033);
    chk("good_exp", exp_seq, 1);

    // Replay of seq0 is a duplicate: ack without output; then a wrong seq is nacked.
    send_frame(12'd0, 3, 1'b0, 1'b0);
    idle(6);
    chk("dup_ack", n_ack, 2);
    chk("dup_no_out", out_log.size(), 3);
    send_frame(12'd5, 2, 1'b0, 1'b0);
    idle(4);
    chk("badseq_nack", n_nack, 2);
    chk("badseq_seq", last_aseq, 5);
    chk("badseq_exp", exp_seq, 1);

    // Fill the buffer with two committed len-32 frames, then stall a third frame's payload.
    ifc.out_ready = 1'b0;
    send_frame(12'd1, 32, 1'b0, 1'b0);
    send_frame(12'd2, 32, 1'b0, 1'b0);
    build_frame(12'd3, 32, 1'b0, 1'b0);
    send_word(txq[0], 1'b0);
    ifc.rx_tlp_valid = 1'b1;
    ifc.rx_tlp_data  = txq[1];
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", ifc.rx_tlp_ready, 0);
    end
    idle(1);
    ifc.out_ready = 1'b1;
    for (int i = 1; i < txq.size(); i++) send_word(txq[i], 1'b0);
    idle(110);
    chk("full_acks", n_ack, 5);
    chk("full_out", out_log.size(), 99);
    chk("full_exp", exp_seq, 4);

    // Illegal lengths are nacked right after the header.
    send_frame(12'd7, 0, 1'b0, 1'b0);
    idle(2);
    chk("len0_nack", n_nack, 3);
    chk("len0_seq", last_aseq, 7);
    send_frame(12'd9, MAX_LEN + 1, 1'b0, 1'b0);
    idle(2);
    chk("lenbig_nack", n_nack, 4);
    chk("lenbig_seq", last_aseq, 9);

    // Reset after two of four payload words: no response, then seq0 is accepted again.
    base_ack  = n_ack;
    base_nack = n_nack;
    build_frame(12'd4, 4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(txq[i], 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("rst_no_ack", n_ack, base_ack);
    chk("rst_no_nack", n_nack, base_nack);
    chk("rst_exp", exp_seq, 0);
    send_frame(12'd0, 2, 1'b0, 1'b0);
    idle(5);
    chk("rst_then_ack", n_ack, base_ack + 1);
    chk("rst_then_exp", exp_seq, 1);

`ifdef TLP_RX_TIMEOUT_EN
    base_nack = n_nack;
    build_frame(12'd1, 4, 1'b0, 1'b0);
    send_word(txq[0], 1'b0);
    send_word(txq[1], 1'b0);
    idle(TIMEOUT + 5);
    chk("tmo_nack", n_nack, base_nack + 1);
    chk("tmo_seq", last_aseq, 1);
`endif

    // Randomized frames, valid gaps and downstream back-pressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int unsigned r, len;
      logic [11:0] seq;
      r = $urandom_range(0, 19);
      len = (r == 0) ? 0 : (r == 1) ? $urandom_range(MAX_LEN + 1, 511) : $urandom_range(1, MAX_LEN);
      r = $urandom_range(0, 3);
      seq = (r < 2) ? 12'(exp_seq) : (r == 2) ? 12'(exp_seq + 4095) : 12'($urandom);
      send_frame(seq, len, $urandom_range(0, 4) == 0, 1'b1);
    end
    rand_rdy = 1'b0;
    ifc.out_ready = 1'b1;
    idle(150);
    chk("drain_empty", ifc.out_valid, 0);

    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
